// File: rtl/reorder_buffer_if.sv
// Reorder buffer bundle: dispatch, CDB, operand lookup, retire and redirect signals.
// Latency: none, wiring only.
// Backpressure: rob_full tells the decoder to stop; there is no other stall path.
interface reorder_buffer_if #(
   parameter int IDX_W = 4
) ();
   logic             rdy;
   logic             iss_valid;
   logic [1:0]       iss_kind;
   logic [4:0]       iss_rd;
   logic [31:0]      iss_pc;
   logic             iss_pred_taken;
   logic [31:0]      iss_target;
   logic [IDX_W-1:0] ROB_idx_out;
   logic             rob_full;
   logic             alu_flag_in;
   logic [31:0]      alu_val_in;
   logic [IDX_W-1:0] alu_to_ROB_in;
   logic             LSB_flag_in;
   logic [31:0]      LSB_val_in;
   logic [IDX_W-1:0] LSB_to_ROB_in;
   logic [IDX_W-1:0] q1_idx;
   logic [IDX_W-1:0] q2_idx;
   logic             q1_ready;
   logic             q2_ready;
   logic [31:0]      q1_val;
   logic [31:0]      q2_val;
   logic             commit_flag;
   logic [4:0]       commit_rd;
   logic [31:0]      commit_val;
   logic [IDX_W-1:0] commit_ROB_idx;
   logic             commit_store;
   logic             jump_wrong;
   logic [31:0]      jump_pc_out;

   // core side that dispatches, broadcasts and consumes retires
   modport master (
      output rdy, iss_valid, iss_kind, iss_rd, iss_pc, iss_pred_taken, iss_target,
      output alu_flag_in, alu_val_in, alu_to_ROB_in, LSB_flag_in, LSB_val_in, LSB_to_ROB_in,
      output q1_idx, q2_idx,
      input  ROB_idx_out, rob_full, q1_ready, q2_ready, q1_val, q2_val,
      input  commit_flag, commit_rd, commit_val, commit_ROB_idx, commit_store,
      input  jump_wrong, jump_pc_out
   );

   // reorder buffer side
   modport slave (
      input  rdy, iss_valid, iss_kind, iss_rd, iss_pc, iss_pred_taken, iss_target,
      input  alu_flag_in, alu_val_in, alu_to_ROB_in, LSB_flag_in, LSB_val_in, LSB_to_ROB_in,
      input  q1_idx, q2_idx,
      output ROB_idx_out, rob_full, q1_ready, q2_ready, q1_val, q2_val,
      output commit_flag, commit_rd, commit_val, commit_ROB_idx, commit_store,
      output jump_wrong, jump_pc_out
   );
endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: tags dispatches, captures CDB results, retires in order, flushes on redirect.
// Latency: one edge from an entry at head becoming ready to its commit pulse; lookups are combinational.
// Backpressure: rob_full blocks dispatch; rdy low freezes all state and silences the pulses.
module reorder_buffer #(
   parameter int ROB_SIZE = 16,
   parameter int IDX_W    = 4
) (
   input logic             clk,
   input logic             rst,
   reorder_buffer_if.slave rob
);
   localparam logic [1:0] K_REG    = 2'd0;
   localparam logic [1:0] K_STORE  = 2'd1;
   localparam logic [1:0] K_BRANCH = 2'd2;
   localparam logic [1:0] K_JALR   = 2'd3;
   localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(ROB_SIZE);

   typedef struct packed {
      logic        busy;
      logic        ready;
      logic [1:0]  kind;
      logic [4:0]  rd;
      logic [31:0] pc;
      logic        pred;
      logic [31:0] target;
      logic [31:0] val;
   } entry_t;

   entry_t           ent_q [ROB_SIZE];
   logic [IDX_W-1:0] head_q, tail_q;
   logic [IDX_W:0]   count_q;
   logic             commit_flag_q, commit_store_q, jump_wrong_q;
   logic [4:0]       commit_rd_q;
   logic [31:0]      commit_val_q, jump_pc_q;
   logic [IDX_W-1:0] commit_idx_q;

   entry_t           head_e;
   logic             full, do_issue, do_commit, taken, redirect, alu_hit, lsb_hit;
   logic [4:0]       commit_rd_d;
   logic [31:0]      commit_val_d, jump_pc_d;
   logic             q1_alu, q1_lsb, q2_alu, q2_lsb;

   // retire/issue decisions and the values a retire would register
   always_comb begin
      head_e       = ent_q[head_q];
      full         = (count_q == FULL_CNT);
      do_issue     = rob.rdy & rob.iss_valid & ~full & ~jump_wrong_q;
      do_commit    = rob.rdy & ~jump_wrong_q & head_e.busy & head_e.ready;
      taken        = head_e.val[0];
      redirect     = do_commit & (((head_e.kind == K_BRANCH) & (taken != head_e.pred)) |
                                  (head_e.kind == K_JALR));
      commit_rd_d  = ((head_e.kind == K_REG) || (head_e.kind == K_JALR)) ? head_e.rd : 5'd0;
      commit_val_d = (head_e.kind == K_JALR) ? head_e.pc + 32'd4 : head_e.val;
      if (head_e.kind == K_JALR)
         jump_pc_d = {head_e.val[31:1], 1'b0};
      else
         jump_pc_d = taken ? head_e.target : head_e.pc + 32'd4;
      // results only land on live entries still waiting for them
      alu_hit = rob.rdy & ~jump_wrong_q & rob.alu_flag_in &
                ent_q[rob.alu_to_ROB_in].busy & ~ent_q[rob.alu_to_ROB_in].ready;
      lsb_hit = rob.rdy & ~jump_wrong_q & rob.LSB_flag_in &
                ent_q[rob.LSB_to_ROB_in].busy & ~ent_q[rob.LSB_to_ROB_in].ready;
   end

   // operand lookup with same-cycle CDB bypass, ALU taking priority
   always_comb begin
      q1_alu       = rob.alu_flag_in & (rob.alu_to_ROB_in == rob.q1_idx);
      q1_lsb       = rob.LSB_flag_in & (rob.LSB_to_ROB_in == rob.q1_idx);
      q2_alu       = rob.alu_flag_in & (rob.alu_to_ROB_in == rob.q2_idx);
      q2_lsb       = rob.LSB_flag_in & (rob.LSB_to_ROB_in == rob.q2_idx);
      rob.q1_ready = ent_q[rob.q1_idx].ready | q1_alu | q1_lsb;
      rob.q2_ready = ent_q[rob.q2_idx].ready | q2_alu | q2_lsb;
      rob.q1_val   = q1_alu ? rob.alu_val_in : (q1_lsb ? rob.LSB_val_in : ent_q[rob.q1_idx].val);
      rob.q2_val   = q2_alu ? rob.alu_val_in : (q2_lsb ? rob.LSB_val_in : ent_q[rob.q2_idx].val);
   end

   // entry storage, pointers and registered retire/redirect outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ROB_SIZE; i++) ent_q[i] <= '0;
         head_q         <= '0;
         tail_q         <= '0;
         count_q        <= '0;
         commit_flag_q  <= 1'b0;
         commit_store_q <= 1'b0;
         jump_wrong_q   <= 1'b0;
         commit_rd_q    <= '0;
         commit_val_q   <= '0;
         commit_idx_q   <= '0;
         jump_pc_q      <= '0;
      end else if (!rob.rdy) begin
         // frozen: pulses fall after one cycle so a stall never repeats a retire
         commit_flag_q  <= 1'b0;
         commit_store_q <= 1'b0;
         jump_wrong_q   <= 1'b0;
      end else begin
         commit_flag_q  <= do_commit;
         commit_store_q <= do_commit & (head_e.kind == K_STORE);
         jump_wrong_q   <= redirect;
         if (do_commit) begin
            commit_rd_q  <= commit_rd_d;
            commit_val_q <= commit_val_d;
            commit_idx_q <= head_q;
         end
         if (redirect) begin
            // everything younger than the redirecting entry is wrong-path
            jump_pc_q <= jump_pc_d;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            for (int i = 0; i < ROB_SIZE; i++) begin
               ent_q[i].busy  <= 1'b0;
               ent_q[i].ready <= 1'b0;
            end
         end else begin
            if (do_commit) begin
               ent_q[head_q].busy  <= 1'b0;
               ent_q[head_q].ready <= 1'b0;
               head_q              <= head_q + IDX_W'(1);
            end
            if (lsb_hit) begin
               ent_q[rob.LSB_to_ROB_in].val   <= rob.LSB_val_in;
               ent_q[rob.LSB_to_ROB_in].ready <= 1'b1;
            end
            if (alu_hit) begin
               ent_q[rob.alu_to_ROB_in].val   <= rob.alu_val_in;
               ent_q[rob.alu_to_ROB_in].ready <= 1'b1;
            end
            if (do_issue) begin
               ent_q[tail_q] <= '{busy: 1'b1, ready: (rob.iss_kind == K_STORE),
                                  kind: rob.iss_kind, rd: rob.iss_rd, pc: rob.iss_pc,
                                  pred: rob.iss_pred_taken, target: rob.iss_target,
                                  val: 32'd0};
               tail_q <= tail_q + IDX_W'(1);
            end
            count_q <= count_q + (IDX_W+1)'(do_issue) - (IDX_W+1)'(do_commit);
         end
      end
   end

   assign rob.ROB_idx_out    = tail_q;
   assign rob.rob_full       = full;
   assign rob.commit_flag    = commit_flag_q;
   assign rob.commit_rd      = commit_rd_q;
   assign rob.commit_val     = commit_val_q;
   assign rob.commit_ROB_idx = commit_idx_q;
   assign rob.commit_store   = commit_store_q;
   assign rob.jump_wrong     = jump_wrong_q;
   assign rob.jump_pc_out    = jump_pc_q;
endmodule
